// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast port among NUM_REQ functional units.
// Each FU owns a one-entry holding slot so a losing FU stalls only itself.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PREG_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_squash,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*PREG_W-1:0]  i_req_preg,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_cdb_valid,
  output logic [PREG_W-1:0]          o_cdb_preg,
  output logic [DATA_W-1:0]          o_cdb_data,
  output logic [NUM_REQ-1:0]         o_cdb_src,
  output logic                       o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]  r_slot_vld_p0;
  logic [PREG_W-1:0]   r_slot_preg_p0 [NUM_REQ];
  logic [DATA_W-1:0]   r_slot_data_p0 [NUM_REQ];
  logic [PTR_W-1:0]    r_rr_ptr;

  logic                r_cdb_vld_p1;
  logic [PREG_W-1:0]   r_cdb_preg_p1;
  logic [DATA_W-1:0]   r_cdb_data_p1;
  logic [NUM_REQ-1:0]  r_cdb_src_p1;

  logic [PREG_W-1:0]   w_req_preg [NUM_REQ];
  logic [DATA_W-1:0]   w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_any;
  logic [PTR_W-1:0]    w_win_idx;
  logic [PTR_W-1:0]    w_rr_next;
  logic [NUM_REQ-1:0]  w_accept;
  logic [NUM_REQ-1:0]  w_load;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_preg[g] = i_req_preg[g*PREG_W +: PREG_W];
      assign w_req_data[g] = i_req_data[g*DATA_W +: DATA_W];
      // A zero tag is accepted like any other completion but never occupies the slot.
      assign w_load[g]     = w_accept[g] && (w_req_preg[g] != '0);
    end
  endgenerate

  // Grant depends only on held slots and the pointer, so req_valid never loops into req_ready.
  always_comb begin
    int               idx_full;
    logic [PTR_W-1:0] idx;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_win_idx   = '0;
    idx_full    = 0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_full = (int'(r_rr_ptr) + k) % NUM_REQ;
      idx      = PTR_W'(idx_full);
      if (!w_grant_any && r_slot_vld_p0[idx]) begin
        w_grant[idx] = 1'b1;
        w_grant_any  = 1'b1;
        w_win_idx    = idx;
      end
    end
  end

  assign w_rr_next   = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
  assign o_req_ready = (reset || i_squash) ? '0 : (~r_slot_vld_p0 | w_grant);
  assign w_accept    = i_req_valid & o_req_ready;

  // Stage p0: per-FU holding slots
  always_ff @(posedge clk) begin
    if (reset || i_squash) begin
      r_slot_vld_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i])
          r_slot_vld_p0[i] <= w_load[i];
        else if (w_grant[i])
          r_slot_vld_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_load[i]) begin
        r_slot_preg_p0[i] <= w_req_preg[i];
        r_slot_data_p0[i] <= w_req_data[i];
      end
    end
  end

  // Stage p1: registered CDB broadcast
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdb_vld_p1  <= 1'b0;
      r_cdb_preg_p1 <= '0;
      r_cdb_data_p1 <= '0;
      r_cdb_src_p1  <= '0;
      r_rr_ptr      <= '0;
    end else if (i_squash) begin
      r_cdb_vld_p1  <= 1'b0;
      r_cdb_src_p1  <= '0;
      r_rr_ptr      <= '0;
    end else if (w_grant_any) begin
      r_cdb_vld_p1  <= 1'b1;
      r_cdb_preg_p1 <= r_slot_preg_p0[w_win_idx];
      r_cdb_data_p1 <= r_slot_data_p0[w_win_idx];
      r_cdb_src_p1  <= w_grant;
      r_rr_ptr      <= w_rr_next;
    end else begin
      r_cdb_vld_p1  <= 1'b0;
      r_cdb_src_p1  <= '0;
    end
  end

  assign o_cdb_valid = r_cdb_vld_p1;
  assign o_cdb_preg  = r_cdb_preg_p1;
  assign o_cdb_data  = r_cdb_data_p1;
  assign o_cdb_src   = r_cdb_src_p1;
  assign o_busy      = (|r_slot_vld_p0) | r_cdb_vld_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: completions are queued when accepted and matched against each broadcast.
module tb_cdb_arbiter;

  logic         clk;
  logic         reset;
  logic         squash;
  logic [3:0]   req_valid;
  logic [23:0]  req_preg;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [5:0]   cdb_preg;
  logic [31:0]  cdb_data;
  logic [3:0]   cdb_src;
  logic         busy;

  typedef struct packed {
    logic [3:0]  src;
    logic [5:0]  preg;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [3:0] tb_rdy;
  logic [3:0] tb_acc;

  cdb_arbiter #(.NUM_REQ(4), .PREG_W(6), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_squash    (squash),
    .i_req_valid (req_valid),
    .i_req_preg  (req_preg),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_cdb_valid (cdb_valid),
    .o_cdb_preg  (cdb_preg),
    .o_cdb_data  (cdb_data),
    .o_cdb_src   (cdb_src),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_fu(input int i, input logic [5:0] p, input logic [31:0] d);
    req_preg[i*6 +: 6]   = p;
    req_data[i*32 +: 32] = d;
  endtask

  // Samples ready mid-cycle, records accepted nonzero tags, then advances to just past the next edge.
  task automatic cycle();
    logic [5:0] p;
    #1;
    tb_rdy = req_ready;
    tb_acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        tb_acc[i] = 1'b1;
        p = req_preg[i*6 +: 6];
        if (p != 6'd0) q.push_back('{src: 4'(1 << i), preg: p, data: req_data[i*32 +: 32]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin
    if (cdb_valid) begin
      if (q.size() == 0) begin
        chk("cdb_unexpected", cdb_valid, 1'b0);
      end else begin
        mon_e = q.pop_front();
        chk("cdb_src",  cdb_src,  mon_e.src);
        chk("cdb_preg", cdb_preg, mon_e.preg);
        chk("cdb_data", cdb_data, mon_e.data);
      end
    end
  end

  initial begin
    int t1, t3, low1, low3, max1, max3;
    reset = 1'b1; squash = 1'b0; req_valid = '0; req_preg = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_preg",  cdb_preg, 0);
    chk("rst_cdb_data",  cdb_data, 0);
    chk("rst_cdb_src",   cdb_src, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_ready",     req_ready, 4'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 4'hF);
    @(posedge clk); #1;

    // single completion
    req_valid = 4'b0001; set_fu(0, 6'd5, 32'hAB);
    cycle();
    req_valid = '0;
    chk("t1_valid_load_edge", cdb_valid, 0);
    chk("t1_busy", busy, 1);
    cycle();
    chk("t1_valid", cdb_valid, 1);
    chk("t1_preg", cdb_preg, 6'd5);
    chk("t1_data", cdb_data, 32'hAB);
    cycle();
    chk("t1_valid_after", cdb_valid, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_sb_empty", q.size(), 0);

    // back-to-back stream from FU0
    req_valid = 4'b0001; set_fu(0, 6'd1, 32'h1001);
    cycle(); chk("t2_rdy_a", tb_rdy[0], 1);
    set_fu(0, 6'd2, 32'h1002);
    cycle(); chk("t2_rdy_b", tb_rdy[0], 1); chk("t2_cdb_1", cdb_valid, 1);
    set_fu(0, 6'd3, 32'h1003);
    cycle(); chk("t2_rdy_c", tb_rdy[0], 1); chk("t2_cdb_2", cdb_valid, 1);
    req_valid = '0;
    cycle(); chk("t2_cdb_3", cdb_valid, 1);
    cycle(); chk("t2_cdb_idle", cdb_valid, 0);
    chk("t2_sb_empty", q.size(), 0);

    // idle squash pulse returns the pointer to 0, then all four at once
    squash = 1'b1; cycle(); squash = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_fu(i, 6'(10 + i), 32'hC000 + i);
    cycle();
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("t3_cdb_valid", cdb_valid, 1);
      chk("t3_busy", busy, 1);
    end
    cycle();
    chk("t3_busy_drop", busy, 0);
    chk("t3_sb_empty", q.size(), 0);

    // FU1 and FU3 held continuously
    t1 = 20; t3 = 30; low1 = 0; low3 = 0; max1 = 0; max3 = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1010;
      set_fu(1, 6'(t1), 32'hD000 + t1);
      set_fu(3, 6'(t3), 32'hD000 + t3);
      cycle();
      low1 = tb_rdy[1] ? 0 : low1 + 1;
      low3 = tb_rdy[3] ? 0 : low3 + 1;
      if (low1 > max1) max1 = low1;
      if (low3 > max3) max3 = low3;
      if (tb_acc[1]) t1++;
      if (tb_acc[3]) t3++;
    end
    drain(4);
    chk("t4_fu1_low_run", max1, 1);
    chk("t4_fu3_low_run", max3, 1);
    chk("t4_sb_empty", q.size(), 0);

    // squash with slots 0 and 2 pending
    req_valid = 4'b0101; set_fu(0, 6'd40, 32'hE040); set_fu(2, 6'd42, 32'hE042);
    cycle();
    squash = 1'b1; q.delete();
    set_fu(0, 6'd50, 32'hE050); set_fu(2, 6'd52, 32'hE052);
    cycle();
    chk("t5_rdy_squash", tb_rdy, 4'h0);
    squash = 1'b0; req_valid = '0;
    chk("t5_cdb_valid", cdb_valid, 0);
    chk("t5_busy", busy, 0);
    drain(4);
    chk("t5_sb_empty", q.size(), 0);

    // zero tag is dropped
    req_valid = 4'b0100; set_fu(2, 6'd0, 32'hF00D);
    cycle();
    chk("t6_busy", busy, 0);
    drain(3);
    chk("t6_cdb_valid", cdb_valid, 0);

    // reset with three slots full
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_fu(i, 6'(60 + i), 32'hA060 + i);
    cycle();
    req_valid = '0;
    chk("t7_busy_loaded", busy, 1);
    reset = 1'b1; q.delete();
    cycle();
    chk("t7_cdb_valid", cdb_valid, 0);
    chk("t7_cdb_preg", cdb_preg, 0);
    chk("t7_cdb_data", cdb_data, 0);
    chk("t7_cdb_src", cdb_src, 0);
    chk("t7_busy", busy, 0);
    chk("t7_ready", req_ready, 4'h0);
    reset = 1'b0;
    #1;
    chk("t7_ready_after", req_ready, 4'hF);
    drain(4);
    chk("t7_sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
